// File: rtl/accel_stim_pkg.sv
// Shared types and constants for accel_stim_gen and its UART byte serialiser.
// ACCEL_STIM_PARITY_EN adds the even-parity bit state to the frame FSM.
package accel_stim_pkg;

  typedef enum logic [1:0] {
    MODE_ZERO   = 2'd0,
    MODE_RAND   = 2'd1,
    MODE_CORNER = 2'd2,
    MODE_RAMP   = 2'd3
  } mode_t;

  // x^16+x^14+x^13+x^11+1 as a right-shifting Fibonacci register: taps at bits 0,2,3,5
  localparam logic [15:0] LFSR_TAPS = 16'h002D;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOAD,
    ST_START,
    ST_DATA,
`ifdef ACCEL_STIM_PARITY_EN
    ST_PAR,
`endif
    ST_STOP,
    ST_GAP
  } state_t;

  function automatic logic [15:0] lfsr_step(input logic [15:0] cur);
    return {^(cur & LFSR_TAPS), cur[15:1]};
  endfunction

endpackage

// File: rtl/uart_tx_byte.sv
// Bit timer, bit counter, optional parity and registered serial output for one byte.
// Follows the frame FSM state; ACCEL_STIM_PARITY_EN enables the parity bit.
module uart_tx_byte
  import accel_stim_pkg::*;
#(
  parameter int BAUD_DIV = 16
) (
  input  logic       clk,
  input  logic       rst_n,
  input  state_t     state,
  input  state_t     state_nxt,
  input  logic [7:0] byte_data,
  output logic       tx,
  output logic       bit_end,
  output logic       data_last,
  output logic       tx_done
);

  localparam int TMR_W = $clog2(BAUD_DIV);
  localparam logic [TMR_W-1:0] TMR_LOAD = TMR_W'(BAUD_DIV - 1);

  logic [TMR_W-1:0] bit_tmr;
  logic [2:0]       bit_cnt;
  logic [2:0]       bit_cnt_nxt;
  logic             in_bit;
  logic             tx_nxt;

  always_comb begin
    in_bit = (state == ST_START) || (state == ST_DATA) || (state == ST_STOP);
`ifdef ACCEL_STIM_PARITY_EN
    if (state == ST_PAR) in_bit = 1'b1;
`endif
  end

  assign bit_end   = in_bit && (bit_tmr == '0);
  assign data_last = (bit_cnt == 3'd7);
  assign tx_done   = (state == ST_STOP) && bit_end;

  always_comb begin
    bit_cnt_nxt = '0;
    if (state == ST_DATA) bit_cnt_nxt = bit_end ? bit_cnt + 3'd1 : bit_cnt;
  end

  // Output is driven from the upcoming state so the line changes on the same edge as the FSM.
  always_comb begin
    tx_nxt = 1'b1;
    case (state_nxt)
      ST_START: tx_nxt = 1'b0;
      ST_DATA:  tx_nxt = byte_data[bit_cnt_nxt];
`ifdef ACCEL_STIM_PARITY_EN
      ST_PAR:   tx_nxt = ^byte_data;
`endif
      default:  tx_nxt = 1'b1;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bit_tmr <= TMR_LOAD;
      bit_cnt <= '0;
      tx      <= 1'b1;
    end else begin
      if (!in_bit || bit_tmr == '0) bit_tmr <= TMR_LOAD;
      else                          bit_tmr <= bit_tmr - TMR_W'(1);
      bit_cnt <= bit_cnt_nxt;
      tx      <= tx_nxt;
    end
  end

endmodule

// File: rtl/accel_stim_gen.sv
// Accelerometer stimulus generator: signed samples serialised MSB byte first as UART frames.
// Define ACCEL_STIM_PARITY_EN for 8E1 bytes; default build sends 8N1.
//
// state | meaning
// IDLE  | line high, waiting for enable
// LOAD  | pick sample for latched mode, advance that mode's generator
// START | start bit (0)
// DATA  | eight data bits, LSB first
// PAR   | even parity bit (parity builds only)
// STOP  | stop bit (1); next byte or end of frame
// GAP   | idle-high spacing between frames
module accel_stim_gen
  import accel_stim_pkg::*;
#(
  parameter int          DATA_W    = 14,
  parameter int          BAUD_DIV  = 16,
  parameter int          GAP_CYC   = 32,
  parameter logic [15:0] LFSR_SEED = 16'hACE1,
  parameter int          RAMP_STEP = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              enable,
  input  logic [1:0]        mode,
  output logic              TX_A,
  output logic              frame_sent,
  output logic [15:0]       frame_cnt,
  output logic [DATA_W-1:0] sample_out
);

  localparam int NB    = (DATA_W + 7) / 8;
  localparam int EXT_W = NB * 8;
  localparam int GAP_W = (GAP_CYC > 1) ? $clog2(GAP_CYC) : 1;
  localparam logic [GAP_W-1:0]  GAP_LOAD = GAP_W'((GAP_CYC > 0) ? GAP_CYC - 1 : 0);
  localparam logic [DATA_W-1:0] SMP_MAX  = {1'b0, {(DATA_W-1){1'b1}}};
  localparam logic [DATA_W-1:0] SMP_MIN  = {1'b1, {(DATA_W-1){1'b0}}};
  localparam logic [DATA_W-1:0] RAMP_INC = DATA_W'(RAMP_STEP);

  state_t            state;
  state_t            state_nxt;
  logic [GAP_W-1:0]  gap_cnt;
  logic [1:0]        byte_idx;
  logic [15:0]       lfsr;
  logic [1:0]        corner_idx;
  logic [DATA_W-1:0] ramp;
  logic [DATA_W-1:0] sample_nxt;
  logic [EXT_W-1:0]  sample_ext;
  logic [7:0]        byte_data;
  logic              bit_end;
  logic              data_last;
  logic              tx_done;
  logic              byte_last;
  logic              gap_end;
  logic              load;
  logic              byte_adv;
  logic              frame_done;

  assign byte_last  = (byte_idx == 2'(NB - 1));
  assign gap_end    = (gap_cnt == '0);
  assign sample_ext = EXT_W'($signed(sample_out));
  assign byte_data  = 8'(sample_ext >> (8 * (NB - 1 - int'(byte_idx))));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ST_IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE:  if (enable) state_nxt = ST_LOAD;
      ST_LOAD:  state_nxt = ST_START;
      ST_START: if (bit_end) state_nxt = ST_DATA;
`ifdef ACCEL_STIM_PARITY_EN
      ST_DATA:  if (bit_end && data_last) state_nxt = ST_PAR;
      ST_PAR:   if (bit_end) state_nxt = ST_STOP;
`else
      ST_DATA:  if (bit_end && data_last) state_nxt = ST_STOP;
`endif
      ST_STOP: begin
        if (tx_done) begin
          if (!byte_last)       state_nxt = ST_START;
          else if (GAP_CYC > 0) state_nxt = ST_GAP;
          else                  state_nxt = enable ? ST_LOAD : ST_IDLE;
        end
      end
      ST_GAP:   if (gap_end) state_nxt = enable ? ST_LOAD : ST_IDLE;
      default:  state_nxt = ST_IDLE;
    endcase
  end

  always_comb begin
    load       = (state == ST_LOAD);
    byte_adv   = tx_done && !byte_last;
    frame_done = tx_done && byte_last;
  end

  always_comb begin
    sample_nxt = '0;
    case (mode_t'(mode))
      MODE_RAND: sample_nxt = lfsr[DATA_W-1:0];
      MODE_CORNER: begin
        case (corner_idx)
          2'd0:    sample_nxt = '0;
          2'd1:    sample_nxt = SMP_MAX;
          2'd2:    sample_nxt = SMP_MIN;
          default: sample_nxt = '1;
        endcase
      end
      MODE_RAMP: sample_nxt = ramp;
      default:   sample_nxt = '0;
    endcase
  end

  // Each generator only moves when its own mode is loaded, so switching modes never skips values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sample_out <= '0;
      frame_cnt  <= '0;
      frame_sent <= 1'b0;
      byte_idx   <= '0;
      gap_cnt    <= GAP_LOAD;
      lfsr       <= LFSR_SEED;
      corner_idx <= '0;
      ramp       <= '0;
    end else begin
      frame_sent <= frame_done;
      if (frame_done) frame_cnt <= frame_cnt + 16'd1;
      if (load) begin
        sample_out <= sample_nxt;
        byte_idx   <= '0;
        case (mode_t'(mode))
          MODE_RAND:   lfsr       <= lfsr_step(lfsr);
          MODE_CORNER: corner_idx <= corner_idx + 2'd1;
          MODE_RAMP:   ramp       <= ramp + RAMP_INC;
          default:     ;
        endcase
      end else if (byte_adv) begin
        byte_idx <= byte_idx + 2'd1;
      end
      if (state == ST_GAP) gap_cnt <= gap_end ? GAP_LOAD : gap_cnt - GAP_W'(1);
      else                 gap_cnt <= GAP_LOAD;
    end
  end

  uart_tx_byte #(
    .BAUD_DIV (BAUD_DIV)
  ) u_tx_byte (
    .clk       (clk),
    .rst_n     (rst_n),
    .state     (state),
    .state_nxt (state_nxt),
    .byte_data (byte_data),
    .tx        (TX_A),
    .bit_end   (bit_end),
    .data_last (data_last),
    .tx_done   (tx_done)
  );

endmodule

// File: tb/tb_accel_stim_gen.sv
// Scoreboard bench for accel_stim_gen: UART line decoder plus frame checker on frame_sent.
// Honours ACCEL_STIM_PARITY_EN for parity-bit checking and frame timing.
`timescale 1ns/1ps
module tb_accel_stim_gen;

  localparam int DATA_W   = 14;
  localparam int BAUD_DIV = 16;
  localparam int GAP_CYC  = 32;
  localparam int NB       = 2;
`ifdef ACCEL_STIM_PARITY_EN
  localparam int P = 1;
`else
  localparam int P = 0;
`endif
  localparam int FRAME_CYC  = NB * (10 + P) * BAUD_DIV;
  localparam int PERIOD_CYC = FRAME_CYC + GAP_CYC + 1;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              enable = 1'b0;
  logic [1:0]        mode = 2'd0;
  logic              TX_A;
  logic              frame_sent;
  logic [15:0]       frame_cnt;
  logic [DATA_W-1:0] sample_out;

  accel_stim_gen #(
    .DATA_W    (DATA_W),
    .BAUD_DIV  (BAUD_DIV),
    .GAP_CYC   (GAP_CYC),
    .LFSR_SEED (16'hACE1),
    .RAMP_STEP (32'h1000)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .enable     (enable),
    .mode       (mode),
    .TX_A       (TX_A),
    .frame_sent (frame_sent),
    .frame_cnt  (frame_cnt),
    .sample_out (sample_out)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] req);
    n_checks++;
    if (obs !== req) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, obs, req, cyc);
    end
  endtask

  logic [DATA_W-1:0] exp_q[$];
  logic [7:0]        rx_q[$];
  int                st_q[$];
  int                fs_hist[$];
  int                frames_done = 0;
  int                cnt_base = 0;
  int                last_start = 0;
  bit                mon_en = 1'b1;

  logic [15:0]       m_lfsr   = 16'hACE1;
  logic [1:0]        m_corner = 2'd0;
  logic [DATA_W-1:0] m_ramp   = '0;

  function automatic logic [DATA_W-1:0] model_sample(input logic [1:0] m);
    logic [DATA_W-1:0] s;
    logic fb;
    s = '0;
    case (m)
      2'd1: begin
        s = m_lfsr[DATA_W-1:0];
        fb = m_lfsr[0] ^ m_lfsr[2] ^ m_lfsr[3] ^ m_lfsr[5];
        m_lfsr = {fb, m_lfsr[15:1]};
      end
      2'd2: begin
        case (m_corner)
          2'd0:    s = 14'h0000;
          2'd1:    s = 14'h1FFF;
          2'd2:    s = 14'h2000;
          default: s = 14'h3FFF;
        endcase
        m_corner = m_corner + 2'd1;
      end
      2'd3: begin
        s = m_ramp;
        m_ramp = m_ramp + 14'h1000;
      end
      default: s = '0;
    endcase
    return s;
  endfunction

  // Line decoder: samples each bit near its middle.
  initial begin : rx_mon
    logic [7:0] b;
    int s0;
    forever begin
      @(negedge clk);
      if (mon_en && rst_n && TX_A === 1'b0) begin
        s0 = cyc;
        repeat (BAUD_DIV / 2 - 1) @(negedge clk);
        check("start_bit", 32'(TX_A), 32'd0);
        for (int i = 0; i < 8; i++) begin
          repeat (BAUD_DIV) @(negedge clk);
          b[i] = TX_A;
        end
`ifdef ACCEL_STIM_PARITY_EN
        repeat (BAUD_DIV) @(negedge clk);
        check("parity_bit", 32'(TX_A), 32'(^b));
`endif
        repeat (BAUD_DIV) @(negedge clk);
        check("stop_bit", 32'(TX_A), 32'd1);
        rx_q.push_back(b);
        st_q.push_back(s0);
      end
    end
  end

  initial begin : fr_chk
    logic [DATA_W-1:0] es;
    logic [15:0] ext;
    int s0;
    bit avail;
    forever begin
      @(negedge clk);
      if (frame_sent === 1'b1) begin
        fs_hist.push_back(cyc);
        check("frame_cnt", 32'(frame_cnt), 32'(frames_done - cnt_base + 1));
        avail = (exp_q.size() > 0) && (rx_q.size() >= NB);
        check("sb_depth", 32'(avail), 32'd1);
        if (avail) begin
          es  = exp_q.pop_front();
          ext = {{(16 - DATA_W){es[DATA_W-1]}}, es};
          check("sample_out", 32'(sample_out), 32'(es));
          check("byte_hi", 32'(rx_q.pop_front()), 32'(ext[15:8]));
          check("byte_lo", 32'(rx_q.pop_front()), 32'(ext[7:0]));
          s0 = st_q.pop_front();
          void'(st_q.pop_front());
          last_start = s0;
          check("frame_dur", 32'(cyc - s0), 32'(FRAME_CYC));
        end
        frames_done++;
      end
    end
  end

  task automatic send(input logic [1:0] m);
    int n;
    n = frames_done;
    mode = m;
    exp_q.push_back(model_sample(m));
    enable = 1'b1;
    for (int k = 0; k < 4 * PERIOD_CYC && frames_done == n; k++) @(negedge clk);
    check("frame_wait", 32'(frames_done - n), 32'd1);
  endtask

  task automatic wait_tx_low(output bit ok);
    ok = 1'b0;
    for (int k = 0; k < 2 * PERIOD_CYC; k++) begin
      @(negedge clk);
      if (TX_A === 1'b0) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic count_low(input int ncyc, output int lows);
    lows = 0;
    for (int k = 0; k < ncyc; k++) begin
      @(negedge clk);
      if (TX_A !== 1'b1) lows++;
    end
  endtask

  initial begin : watchdog
    #600000;
    $display("FAIL watchdog: cycle %0d exceeded limit 60000", cyc);
    $fatal(1, "watchdog");
  end

  initial begin : main
    int e_cyc;
    int lows;
    int n;
    bit ok;

    repeat (3) @(negedge clk);
    check("rst_tx", 32'(TX_A), 32'd1);
    check("rst_frame_sent", 32'(frame_sent), 32'd0);
    check("rst_frame_cnt", 32'(frame_cnt), 32'd0);
    check("rst_sample", 32'(sample_out), 32'd0);
    rst_n = 1'b1;
    repeat (4) @(negedge clk);
    check("idle_tx", 32'(TX_A), 32'd1);

    e_cyc = cyc;
    send(2'd0);
    check("start_latency", 32'(last_start - e_cyc), 32'd2);
    send(2'd0);
    check("period", 32'(fs_hist[1] - fs_hist[0]), 32'(PERIOD_CYC));

    for (int i = 0; i < 4; i++) send(2'd2);

    for (int i = 0; i < 3; i++) send(2'd1);
    send(2'd0);
    for (int i = 0; i < 2; i++) send(2'd1);

    for (int i = 0; i < 5; i++) send(2'd3);

    // Drop enable inside the first byte: frame must still complete, then idle.
    n = frames_done;
    mode = 2'd2;
    exp_q.push_back(model_sample(2'd2));
    wait_tx_low(ok);
    check("drop_frame_start", 32'(ok), 32'd1);
    repeat (40) @(negedge clk);
    enable = 1'b0;
    for (int k = 0; k < 2 * PERIOD_CYC && frames_done == n; k++) @(negedge clk);
    check("drop_frame_done", 32'(frames_done - n), 32'd1);
    count_low(3 * PERIOD_CYC, lows);
    check("idle_after_drop", 32'(lows), 32'd0);
    check("no_extra_frame", 32'(frames_done - n), 32'd1);

    // Reset during the next frame's start bit.
    mon_en = 1'b0;
    enable = 1'b1;
    wait_tx_low(ok);
    check("rst_frame_start", 32'(ok), 32'd1);
    repeat (3) @(negedge clk);
    #2;
    rst_n  = 1'b0;
    enable = 1'b0;
    #1;
    check("rst_async_tx", 32'(TX_A), 32'd1);
    check("rst_async_cnt", 32'(frame_cnt), 32'd0);
    check("rst_async_sample", 32'(sample_out), 32'd0);
    repeat (3) @(negedge clk);
    rst_n    = 1'b1;
    m_lfsr   = 16'hACE1;
    m_corner = 2'd0;
    m_ramp   = '0;
    cnt_base = frames_done;
    count_low(2 * PERIOD_CYC, lows);
    check("no_resume", 32'(lows), 32'd0);

    mon_en = 1'b1;
    e_cyc = cyc;
    send(2'd1);
    check("start_latency_rst", 32'(last_start - e_cyc), 32'd2);
    enable = 1'b0;
    repeat (PERIOD_CYC) @(negedge clk);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/accel_stim_gen.md
# accel_stim_gen

Parametrised accelerometer stimulus generator. It serialises signed acceleration samples as UART frames on `TX_A` for the `cbc_dig` accelerometer receiver. It supersedes the fixed-width, three-mode generator used in the digital-core benches. It adds:
- configurable sample width, baud divisor and inter-frame gap;
- a ramp mode;
- frame counting;
- optional parity.

It is synthesisable, so the same block serves simulation benches and FPGA bring-up.

## Interface
Parameters:
- `DATA_W`, 14: sample width in bits, two's complement, range 8..16.
- `BAUD_DIV`, 16: clocks per UART bit, at least 4.
- `GAP_CYC`, 32: idle-high clocks between frames.
- `LFSR_SEED`, 16'hACE1: random-mode seed, must be non-zero.
- `RAMP_STEP`, 1: increment per frame in ramp mode.

Ports:
- `clk`  in  1  system clock.
- `rst_n`  in  1  reset. One clock; reset is asynchronous and active-low.
- `enable`  in  1  frames are generated while high.
- `mode`  in  2  0 = zero, 1 = LFSR random, 2 = corner cycle, 3 = ramp.
- `TX_A`  out  1  UART serial output, idle high.
- `frame_sent`  out  1  one-cycle pulse after the last stop bit of each frame.
- `frame_cnt`  out  16  frames completed since reset, wraps.
- `sample_out`  out  DATA_W  sample currently or most recently transmitted.

## Operation
- Frame layout: NB = ceil(DATA_W/8) bytes, most-significant byte first. The sample is sign-extended to NB*8 bits.
- Byte format: 8N1, LSB first. One start bit (0), 8 data bits, one stop bit (1).
- FSM states: IDLE, LOAD, START, DATA, PAR (only when parity is compiled in), STOP, GAP.
  - IDLE → LOAD when `enable` = 1.
  - LOAD: latches `mode`, computes the sample, writes `sample_out`, sets byte index to 0. → START.
  - START → DATA → (PAR) → STOP. Each bit lasts BAUD_DIV clocks.
  - STOP: if bytes remain, increment the byte index and go to START. Otherwise pulse `frame_sent`, increment `frame_cnt`, and go to GAP.
  - GAP: hold `TX_A` high for GAP_CYC clocks. Then go to LOAD if `enable` = 1, else to IDLE.
- Sample generation, evaluated in LOAD only:
  - Mode 0: the sample is 0.
  - Mode 1: the sample is `lfsr[DATA_W-1:0]`. The LFSR is 16-bit Fibonacci, polynomial x^16+x^14+x^13+x^11+1, and advances once per LOAD in mode 1 only.
  - Mode 2: cycles through 0, +max (2^(DATA_W-1)-1), -min (-2^(DATA_W-1)), -1, then repeats. The cycle index advances per LOAD in mode 2 only.
  - Mode 3: the sample is the ramp accumulator. The accumulator then adds RAMP_STEP modulo 2^DATA_W. It advances per LOAD in mode 3 only.
- Per-mode state (LFSR, corner index, ramp) persists across mode switches. It is reset only by `rst_n`.
- A `mode` change mid-frame is ignored until the next LOAD.
- `enable` deasserted mid-frame: the current frame and its gap complete, then the FSM goes to IDLE. Frames are never truncated.
- `frame_cnt` wraps from 0xFFFF to 0x0000 without a flag.

## Timing
- Reset values:
  - `TX_A` = 1, `frame_sent` = 0, `frame_cnt` = 0, `sample_out` = 0.
  - FSM in IDLE, LFSR = LFSR_SEED, corner index 0, ramp 0.
- Reset asserted mid-frame: `TX_A` goes high asynchronously. No partial frame resumes.
- `enable` rising in IDLE: LOAD occurs on the next edge, and the start bit begins the following cycle.
- Frame duration from start bit to `frame_sent`: NB*(10 + P)*BAUD_DIV clocks, where P = 1 with parity and 0 without.
- Frame period with `enable` held high: frame duration + GAP_CYC + 1 clocks. The extra clock is LOAD.
- `TX_A` is registered. Bit edges are exactly BAUD_DIV clocks apart with no jitter.

## Configuration
- `ACCEL_STIM_PARITY_EN`
  - Defined: each byte carries an even-parity bit after D7 and before the stop bit (8E1), and the PAR state is present.
  - Undefined: 8N1 and the PAR state is absent.

## Structure
- Shared package `accel_stim_pkg`:
  - the mode enum (MODE_ZERO, MODE_RAND, MODE_CORNER, MODE_RAMP);
  - the LFSR tap constant;
  - the FSM state typedef.
- Sub-module `uart_tx_byte`: bit timer, bit counter, optional parity, and `tx_done` pulse. The top-level block owns the frame sequencing and sample generation.

## Test plan
All scenarios use DATA_W = 14, BAUD_DIV = 16 and GAP_CYC = 32 unless stated.
- Reset, then `enable` = 1 with mode 0 → bytes 0x00, 0x00. `frame_sent` fires 320 clocks after the start bit. `frame_cnt` = 1. Period is 353 clocks.
- Mode 2 for four frames → `sample_out` 0x0000, 0x1FFF, 0x2000, 0x3FFF. Bytes are 00/00, 1F/FF, E0/00, FF/FF.
- Mode 1 for three frames → samples match the reference LFSR seeded with 0xACE1, masked to 14 bits. Switch to mode 0 for one frame, then back to mode 1 → the sequence resumes with no LFSR steps skipped.
- Mode 3 with RAMP_STEP = 0x1000 → samples 0x0000, 0x1000, 0x2000, 0x3000, then wraps to 0x0000.
- `enable` dropped during byte 1, then `rst_n` pulsed low during the next frame → the first frame completes and the FSM goes idle. `TX_A` goes high immediately on reset and `frame_cnt` returns to 0.
- With `ACCEL_STIM_PARITY_EN` defined and mode 2 → byte 0x1F carries parity bit 1 and byte 0xFF carries parity bit 0. The frame takes 352 clocks.
